// File: rtl/adsr_pkg.sv
// ==========================================================================
// Module : adsr_pkg
// Brief  : ADSR phase encoding and step type shared by generator and detector.
// Rev    : 1.0  initial release
// ==========================================================================
`default_nettype none

package adsr_pkg;

  typedef logic [2:0] phase_t;

  localparam phase_t PH_IDLE    = 3'd0;
  localparam phase_t PH_ATTACK  = 3'd1;
  localparam phase_t PH_DECAY   = 3'd2;
  localparam phase_t PH_SUSTAIN = 3'd3;
  localparam phase_t PH_RELEASE = 3'd4;

  typedef enum logic [1:0] {
    STEP_FLAT = 2'd0,
    STEP_RISE = 2'd1,
    STEP_FALL = 2'd2
  } step_t;

  // Inverts the generator's (255*a)>>8 = a-1 truncation for a in 1..255.
  function automatic logic [7:0] compensate(input logic [7:0] pk);
    if (pk == 8'd0)
      return 8'd0;
    else if (pk == 8'hFF)
      return 8'hFF;
    else
      return pk + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adsr_envelope_detector_if.sv
// ==========================================================================
// Module : adsr_envelope_detector_if
// Brief  : Sample stream in, envelope/phase results out.
// Rev    : 1.0  initial release
// ==========================================================================
`default_nettype none

interface adsr_envelope_detector_if;
  import adsr_pkg::*;

  logic [7:0] sample;
  logic       sample_valid;
  logic [7:0] envelope;
  logic       env_valid;
  phase_t     phase;
  logic [7:0] peak_hold;
  logic [7:0] sustain_level;

  modport master (
    output sample, sample_valid,
    input  envelope, env_valid, phase, peak_hold, sustain_level
  );

  modport slave (
    input  sample, sample_valid,
    output envelope, env_valid, phase, peak_hold, sustain_level
  );

endinterface

`default_nettype wire

// File: rtl/window_peak_tracker.sv
// ==========================================================================
// Module : window_peak_tracker
// Brief  : Counts valid samples per window and tracks the window maximum.
// Rev    : 1.0  initial release
// ==========================================================================
`default_nettype none

module window_peak_tracker #(
  parameter int WIN_LOG2 = 9
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic [7:0] i_sample,
  input  wire logic       i_valid,
  output logic      [7:0] o_pk,
  output logic            o_close
);

  logic [WIN_LOG2-1:0] r_cnt;
  logic [7:0]          r_acc;
  logic [7:0]          w_max;

  assign w_max   = (i_sample > r_acc) ? i_sample : r_acc;
  // Close and peak are combinational so the consumer registers on the same edge.
  assign o_close = i_valid && (r_cnt == '1);
  assign o_pk    = w_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_acc <= 8'd0;
    end else if (i_valid) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= o_close ? 8'd0 : w_max;
    end
  end

endmodule

`default_nettype wire

// File: rtl/adsr_envelope_detector.sv
// ==========================================================================
// Module : adsr_envelope_detector
// Brief  : Recovers per-window envelope and classifies it into ADSR phases.
// Rev    : 1.0  initial release
// ==========================================================================
`default_nettype none

module adsr_envelope_detector
  import adsr_pkg::*;
#(
  parameter int WIN_LOG2   = 9,
  parameter int THRESH     = 2,
  parameter int FLOOR      = 1,
  parameter int COMPENSATE = 1
) (
  input wire logic                  clk,
  input wire logic                  rst_n,
  adsr_envelope_detector_if.slave   bus
);

  localparam logic signed [9:0] c_thresh = 10'(THRESH);
  localparam logic signed [9:0] c_floor  = 10'(FLOOR);

  logic [7:0]        w_pk;
  logic              w_close;
  logic [7:0]        w_new;
  logic signed [9:0] w_new_s;
  logic signed [9:0] w_prev_s;
  step_t             w_step;
  phase_t            w_phase_nxt;
  logic [7:0]        w_peak_nxt;
  logic [7:0]        w_sus_nxt;

  phase_t            r_phase;
  logic [7:0]        r_env;
  logic              r_env_valid;
  logic [7:0]        r_peak;
  logic [7:0]        r_sus;

  window_peak_tracker #(.WIN_LOG2(WIN_LOG2)) u_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_sample (bus.sample),
    .i_valid  (bus.sample_valid),
    .o_pk     (w_pk),
    .o_close  (w_close)
  );

  assign w_new    = (COMPENSATE != 0) ? compensate(w_pk) : w_pk;
  assign w_new_s  = $signed({2'b00, w_new});
  assign w_prev_s = $signed({2'b00, r_env});

  always_comb begin
    w_step = STEP_FLAT;
    if (w_new_s > w_prev_s + c_thresh)
      w_step = STEP_RISE;
    else if (w_new_s + c_thresh < w_prev_s)
      w_step = STEP_FALL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_phase <= PH_IDLE;
    else if (w_close)
      r_phase <= w_phase_nxt;
  end

  always_comb begin
    w_phase_nxt = r_phase;
    if (w_new_s <= c_floor) begin
      w_phase_nxt = PH_IDLE;
    end else begin
      case (r_phase)
        PH_IDLE:    w_phase_nxt = PH_ATTACK;
        PH_ATTACK:  if (w_step == STEP_FALL)      w_phase_nxt = PH_DECAY;
                    else if (w_step == STEP_FLAT) w_phase_nxt = PH_SUSTAIN;
        PH_DECAY:   if (w_step == STEP_FLAT)      w_phase_nxt = PH_SUSTAIN;
                    else if (w_step == STEP_RISE) w_phase_nxt = PH_ATTACK;
        PH_SUSTAIN: if (w_step == STEP_FALL)      w_phase_nxt = PH_RELEASE;
                    else if (w_step == STEP_RISE) w_phase_nxt = PH_ATTACK;
        PH_RELEASE: if (w_step == STEP_RISE)      w_phase_nxt = PH_ATTACK;
        default:    w_phase_nxt = PH_IDLE;
      endcase
    end
  end

  always_comb begin
    w_peak_nxt = r_peak;
    w_sus_nxt  = r_sus;
    if (w_phase_nxt == PH_ATTACK) begin
      if (r_phase != PH_ATTACK)
        w_peak_nxt = w_new;
      else if (w_new > r_peak)
        w_peak_nxt = w_new;
    end
    if (w_phase_nxt == PH_SUSTAIN && r_phase != PH_SUSTAIN)
      w_sus_nxt = w_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_env       <= 8'd0;
      r_env_valid <= 1'b0;
      r_peak      <= 8'd0;
      r_sus       <= 8'd0;
    end else begin
      r_env_valid <= w_close;
      if (w_close) begin
        r_env  <= w_new;
        r_peak <= w_peak_nxt;
        r_sus  <= w_sus_nxt;
      end
    end
  end

  assign bus.envelope      = r_env;
  assign bus.env_valid     = r_env_valid;
  assign bus.phase         = r_phase;
  assign bus.peak_hold     = r_peak;
  assign bus.sustain_level = r_sus;

endmodule

`default_nettype wire

// File: tb/tb_adsr_envelope_detector.sv
// ==========================================================================
// Module : tb_adsr_envelope_detector
// Brief  : Directed self-checking bench for the ADSR envelope detector.
// Rev    : 1.0  initial release
// ==========================================================================
`default_nettype none

module tb_adsr_envelope_detector;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;
  int   n_pulse = 0;

  adsr_envelope_detector_if bus0 ();
  adsr_envelope_detector_if bus1 ();

  assign bus1.sample       = bus0.sample;
  assign bus1.sample_valid = bus0.sample_valid;

  adsr_envelope_detector #(.WIN_LOG2(9), .THRESH(2), .FLOOR(1), .COMPENSATE(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  adsr_envelope_detector #(.WIN_LOG2(9), .THRESH(2), .FLOOR(1), .COMPENSATE(0)) dut_nc (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus0.env_valid === 1'b1) n_pulse <= n_pulse + 1;

  task automatic do_reset();
    rst_n = 1'b0;
    bus0.sample = 8'd0;
    bus0.sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_pulse = 0;
  endtask

  // Triangle 0..255..0 scaled by amp the way the generator does: peak = amp-1.
  task automatic feed_window(input int amp, input bit gap);
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      bus0.sample = 8'((((i < 256) ? i : 511 - i) * amp) >> 8);
      bus0.sample_valid = 1'b1;
      if (gap) begin
        @(negedge clk);
        bus0.sample_valid = 1'b0;
      end
    end
    if (!gap) begin
      @(negedge clk);
      bus0.sample_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({bus0.envelope, bus0.env_valid, bus0.phase, bus0.peak_hold, bus0.sustain_level} !== 28'd0) begin
      n_bad++;
      $display("FAIL reset_outputs env=%0d vld=%0d ph=%0d pk=%0d sus=%0d want all 0",
               bus0.envelope, bus0.env_valid, bus0.phase, bus0.peak_hold, bus0.sustain_level);
    end
  endtask

  task automatic test_steady(input bit gap, input string nm);
    do_reset();
    feed_window(100, gap);
    n_total++;
    if (bus0.env_valid !== 1'b1 || bus0.envelope !== 8'd100 || bus0.phase !== 3'd1 || bus0.peak_hold !== 8'd100) begin
      n_bad++;
      $display("FAIL %s_w1 vld=%0d env=%0d ph=%0d pk=%0d want 1/100/1/100",
               nm, bus0.env_valid, bus0.envelope, bus0.phase, bus0.peak_hold);
    end
    @(negedge clk); #1;
    n_total++;
    if (bus0.env_valid !== 1'b0 || n_pulse !== 1) begin
      n_bad++;
      $display("FAIL %s_pulse1 vld=%0d pulses=%0d want 0/1", nm, bus0.env_valid, n_pulse);
    end
    feed_window(100, gap);
    n_total++;
    if (bus0.phase !== 3'd3 || bus0.sustain_level !== 8'd100 || bus0.envelope !== 8'd100 || bus0.peak_hold !== 8'd100) begin
      n_bad++;
      $display("FAIL %s_w2 ph=%0d sus=%0d env=%0d pk=%0d want 3/100/100/100",
               nm, bus0.phase, bus0.sustain_level, bus0.envelope, bus0.peak_hold);
    end
    @(negedge clk); #1;
    n_total++;
    if (n_pulse !== 2) begin
      n_bad++;
      $display("FAIL %s_pulse2 pulses=%0d want 2", nm, n_pulse);
    end
  endtask

  task automatic test_full_envelope();
    int amps [10] = '{0, 40, 80, 120, 90, 60, 60, 60, 30, 0};
    int envs [10] = '{0, 40, 80, 120, 90, 60, 60, 60, 30, 0};
    int phs  [10] = '{0, 1, 1, 1, 2, 2, 3, 3, 4, 0};
    do_reset();
    for (int w = 0; w < 10; w++) begin
      feed_window(amps[w], 1'b0);
      n_total++;
      if (bus0.envelope !== 8'(envs[w]) || bus0.phase !== 3'(phs[w])) begin
        n_bad++;
        $display("FAIL full_env_w%0d env=%0d ph=%0d want %0d/%0d",
                 w, bus0.envelope, bus0.phase, envs[w], phs[w]);
      end
    end
    n_total++;
    if (bus0.peak_hold !== 8'd120 || bus0.sustain_level !== 8'd60) begin
      n_bad++;
      $display("FAIL full_env_hold pk=%0d sus=%0d want 120/60", bus0.peak_hold, bus0.sustain_level);
    end
  endtask

  task automatic test_dead_band();
    int amps [8] = '{100, 100, 102, 100, 103, 100, 100, 97};
    int phs  [8] = '{1, 3, 3, 3, 1, 2, 3, 4};
    do_reset();
    for (int w = 0; w < 8; w++) begin
      feed_window(amps[w], 1'b0);
      n_total++;
      if (bus0.envelope !== 8'(amps[w]) || bus0.phase !== 3'(phs[w])) begin
        n_bad++;
        $display("FAIL dead_band_w%0d env=%0d ph=%0d want %0d/%0d",
                 w, bus0.envelope, bus0.phase, amps[w], phs[w]);
      end
    end
    n_total++;
    if (bus0.peak_hold !== 8'd103 || bus0.sustain_level !== 8'd100) begin
      n_bad++;
      $display("FAIL dead_band_hold pk=%0d sus=%0d want 103/100", bus0.peak_hold, bus0.sustain_level);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    feed_window(255, 1'b0);
    n_total++;
    if (bus0.envelope !== 8'd255 || bus0.phase !== 3'd1) begin
      n_bad++;
      $display("FAIL sat_pk254 env=%0d ph=%0d want 255/1", bus0.envelope, bus0.phase);
    end
    feed_window(256, 1'b0);
    n_total++;
    if (bus0.envelope !== 8'd255 || bus0.phase !== 3'd3 || bus0.sustain_level !== 8'd255) begin
      n_bad++;
      $display("FAIL sat_pk255 env=%0d ph=%0d sus=%0d want 255/3/255",
               bus0.envelope, bus0.phase, bus0.sustain_level);
    end
    feed_window(0, 1'b0);
    n_total++;
    if (bus0.envelope !== 8'd0 || bus0.phase !== 3'd0 || bus0.env_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_zero env=%0d ph=%0d vld=%0d want 0/0/1",
               bus0.envelope, bus0.phase, bus0.env_valid);
    end
  endtask

  task automatic test_nocomp();
    do_reset();
    feed_window(100, 1'b0);
    n_total++;
    if (bus1.envelope !== 8'd99 || bus1.phase !== 3'd1 || bus1.peak_hold !== 8'd99) begin
      n_bad++;
      $display("FAIL nocomp env=%0d ph=%0d pk=%0d want 99/1/99",
               bus1.envelope, bus1.phase, bus1.peak_hold);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    feed_window(100, 1'b0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus0.sample = 8'((((i < 256) ? i : 511 - i) * 100) >> 8);
      bus0.sample_valid = 1'b1;
    end
    #2 rst_n = 1'b0;
    bus0.sample_valid = 1'b0;
    #1;
    n_total++;
    if ({bus0.envelope, bus0.env_valid, bus0.phase, bus0.peak_hold, bus0.sustain_level} !== 28'd0) begin
      n_bad++;
      $display("FAIL async_rst_outputs env=%0d vld=%0d ph=%0d pk=%0d sus=%0d want all 0",
               bus0.envelope, bus0.env_valid, bus0.phase, bus0.peak_hold, bus0.sustain_level);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_pulse = 0;
    feed_window(100, 1'b0);
    n_total++;
    if (bus0.envelope !== 8'd100 || bus0.phase !== 3'd1 || bus0.peak_hold !== 8'd100 || bus0.sustain_level !== 8'd0) begin
      n_bad++;
      $display("FAIL async_rst_window env=%0d ph=%0d pk=%0d sus=%0d want 100/1/100/0",
               bus0.envelope, bus0.phase, bus0.peak_hold, bus0.sustain_level);
    end
    @(negedge clk); #1;
    n_total++;
    if (n_pulse !== 1) begin
      n_bad++;
      $display("FAIL async_rst_pulses pulses=%0d want 1", n_pulse);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus0.sample = 8'd0;
    bus0.sample_valid = 1'b0;
    test_reset();
    test_steady(1'b0, "steady");
    test_full_envelope();
    test_dead_band();
    test_saturation();
    test_nocomp();
    test_steady(1'b1, "valid_gaps");
    test_async_reset();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
